ksa_share_arbiter: RTL and testbench

- Shares one 16-bit Kogge-Stone adder among NREQ requesters using round-robin arbitration.
- Supports multi-word (carry-chained) additions. A requester issues successive 16-bit beats, and the block feeds each beat's carry-out into the next beat's Cin.
- While a chain is in progress, the grant stays locked to the requester that owns the chain.
- The adder is instantiated outside this block and connected through the add_* ports. The adder is combinational; this block registers its result.

---
 rtl/ksa_share_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ksa_share_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ksa_share_arbiter.sv
// Round-robin share of one external W-bit adder among NREQ requesters,
// with carry-chained multi-word beats and a one-entry result register.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready per-requester beat handshake (ready one-hot or 0)
//   req_x/req_y         packed operands, requester i at [i*W +: W]
//   req_last            beat closes its chain
//   add_x/add_y/add_cin drive the external adder
//   add_s               adder result, add_s[W] is carry-out
//   rsp_valid/rsp_ready result handshake
//   rsp_id/rsp_sum      result owner and sum word
//   rsp_cout/rsp_last   beat carry-out and last flag
//   busy                chain locked or result pending
module ksa_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ-1:0]   req_last,
  output logic [W-1:0]      add_x,
  output logic [W-1:0]      add_y,
  output logic              add_cin,
  input  logic [W:0]        add_s,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_last,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_owner;
  logic [IDW-1:0] r_rr;
  logic           r_carry;

  logic           r_rsp_valid;
  logic [IDW-1:0] r_rsp_id;
  logic [W-1:0]   r_rsp_sum;
  logic           r_rsp_cout;
  logic           r_rsp_last;

  logic           w_hit;
  logic [IDW-1:0] w_gnt;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_sel;
  logic           w_slot_free;
  logic           w_acc;
  logic           w_last;
  logic [IDW-1:0] w_rr_nxt;
  logic [NREQ-1:0] w_ready;
  logic [W-1:0]   w_x;
  logic [W-1:0]   w_y;

  assign w_slot_free = !r_rsp_valid | rsp_ready;

  // Grant search: cyclic from rr in IDLE, owner only in LOCK.
  always_comb begin
    w_hit = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    if (r_state == LOCK) begin
      w_gnt = r_owner;
      w_hit = req_valid[r_owner];
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        w_idx = IDW'((int'(r_rr) + k) % NREQ);
        if (!w_hit && req_valid[w_idx]) begin
          w_hit = 1'b1;
          w_gnt = w_idx;
        end
      end
    end
  end

  assign w_acc  = w_hit & w_slot_free;
  assign w_sel  = w_hit ? w_gnt : '0;
  assign w_last = req_last[w_sel];

  assign w_rr_nxt = (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;

  always_comb begin
    w_ready = '0;
    if (w_acc) w_ready[w_gnt] = 1'b1;
  end

  always_comb begin
    w_x = req_x[W-1:0];
    w_y = req_y[W-1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (w_sel == IDW'(i)) begin
        w_x = req_x[i*W +: W];
        w_y = req_y[i*W +: W];
      end
    end
  end

  assign add_x   = w_x;
  assign add_y   = w_y;
  // First beats always start from zero carry.
  assign add_cin = (r_state == LOCK) & w_hit & r_carry;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_acc && !w_last) w_state_nxt = LOCK;
      LOCK: if (w_acc && w_last)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_rr        <= '0;
      r_carry     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
      r_rsp_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= w_gnt;
        r_rsp_sum   <= add_s[W-1:0];
        r_rsp_cout  <= add_s[W];
        r_rsp_last  <= w_last;
        r_carry     <= add_s[W];
        if (r_state == IDLE) r_owner <= w_gnt;
        if (w_last) r_rr <= w_rr_nxt;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;
  assign rsp_last  = r_rsp_last;
  assign busy      = (r_state == LOCK) | r_rsp_valid;

endmodule

// File: tb/tb_ksa_share_arbiter.sv
// Directed bench for ksa_share_arbiter with a behavioural adder
// standing in for the external Kogge-Stone unit.
module tb_ksa_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ-1:0]   req_last;
  logic [W-1:0]      add_x;
  logic [W-1:0]      add_y;
  logic              add_cin;
  logic [W:0]        add_s;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              rsp_last;
  logic              busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign add_s = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};

  ksa_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_last  (req_last),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_last  (rsp_last),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic l);
    req_valid[i]     = v;
    req_x[i*W +: W]  = x;
    req_y[i*W +: W]  = y;
    req_last[i]      = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic [IDW-1:0] id,
                         input logic [W-1:0] sum, input logic co,
                         input logic l);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".id"},    32'(rsp_id),    32'(id));
    chk({tag, ".sum"},   32'(rsp_sum),   32'(sum));
    chk({tag, ".cout"},  32'(rsp_cout),  32'(co));
    chk({tag, ".last"},  32'(rsp_last),  32'(l));
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    req_last  = '0;
    tick();
    tick();
    chk("rst.valid", 32'(rsp_valid), 32'd0);
    chk("rst.busy",  32'(busy),      32'd0);
    chk("rst.sum",   32'(rsp_sum),   32'd0);
    chk("rst.id",    32'(rsp_id),    32'd0);
    chk("rst.ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    // single beat, requester 1
    set_req(1, 1'b1, 16'hFFFF, 16'h0001, 1'b1);
    #1;
    chk("one.ready", 32'(req_ready), 32'h2);
    chk("one.cin",   32'(add_cin),   32'd0);
    tick();
    req_valid = '0;
    chk_rsp("one", 2'd1, 16'h0000, 1'b1, 1'b1);
    tick();
    chk("one.drain", 32'(rsp_valid), 32'd0);

    // two-word chain on 2 while 0 waits; rr now 2
    set_req(2, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    set_req(0, 1'b1, 16'h0005, 16'h0006, 1'b1);
    #1;
    chk("ch.rdy0", 32'(req_ready), 32'h4);
    tick();
    chk_rsp("ch.b0", 2'd2, 16'h0000, 1'b1, 1'b0);
    chk("ch.busy", 32'(busy), 32'd1);
    set_req(2, 1'b1, 16'h0000, 16'h0000, 1'b1);
    #1;
    chk("ch.rdy1", 32'(req_ready), 32'h4);
    chk("ch.cin",  32'(add_cin),   32'd1);
    tick();
    chk_rsp("ch.b1", 2'd2, 16'h0001, 1'b0, 1'b1);
    req_valid[2] = 1'b0;
    #1;
    chk("ch.rdy2", 32'(req_ready), 32'h1);
    tick();
    chk_rsp("ch.r0", 2'd0, 16'h000B, 1'b0, 1'b1);
    req_valid = '0;
    tick();

    // reset to bring rr back to 0, then round robin
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++)
      set_req(i, 1'b1, 16'(16'h0101 * i), 16'h1000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr.ready", 32'(req_ready), 32'(1 << (k % NREQ)));
      tick();
      chk_rsp("rr", 2'(k % NREQ),
              16'(16'h1000 + 16'h0101 * (k % NREQ)), 1'b0, 1'b1);
    end

    // backpressure with requester 0's result held; rr now 1
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp.ready", 32'(req_ready), 32'd0);
      tick();
      chk_rsp("bp.hold", 2'd0, 16'h1000, 1'b0, 1'b1);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp.rise", 32'(req_ready), 32'h2);
    tick();
    chk_rsp("bp.next", 2'd1, 16'h1101, 1'b0, 1'b1);
    req_valid = '0;
    tick();
    chk("bp.drain", 32'(rsp_valid), 32'd0);

    // reset mid-chain on requester 3
    set_req(3, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    tick();
    chk("rm.busy", 32'(busy), 32'd1);
    chk("rm.cout", 32'(rsp_cout), 32'd1);
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    chk("rm.valid", 32'(rsp_valid), 32'd0);
    chk("rm.busy0", 32'(busy), 32'd0);
    set_req(3, 1'b1, 16'h0001, 16'h0001, 1'b0);
    #1;
    chk("rm.cin",   32'(add_cin),   32'd0);
    chk("rm.ready", 32'(req_ready), 32'h8);
    tick();
    chk_rsp("rm.b", 2'd3, 16'h0002, 1'b0, 1'b0);

    // owner stall in LOCK with carry 1 saved
    set_req(3, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    tick();
    chk_rsp("st.b", 2'd3, 16'h0000, 1'b1, 1'b0);
    req_valid[3] = 1'b0;
    set_req(1, 1'b1, 16'h0003, 16'h0004, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("st.ready", 32'(req_ready), 32'd0);
      tick();
      chk("st.busy", 32'(busy), 32'd1);
    end
    set_req(3, 1'b1, 16'h0000, 16'h0000, 1'b1);
    #1;
    chk("st.cin",   32'(add_cin),   32'd1);
    chk("st.ready", 32'(req_ready), 32'h8);
    tick();
    chk_rsp("st.end", 2'd3, 16'h0001, 1'b0, 1'b1);
    req_valid[3] = 1'b0;
    #1;
    chk("st.next", 32'(req_ready), 32'h2);
    tick();
    chk_rsp("st.r1", 2'd1, 16'h0007, 1'b0, 1'b1);
    req_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
